// File: rtl/dd_timeout_sched.sv
// Per-flow retransmission-timer scheduler: one deadline per flow, round-robin expiry scan,
// and one timeout event at a time on a valid/ready port.
module dd_timeout_sched #(
    parameter int FLOW_NUM  = 16,
    parameter int FLOW_ID_W = 4,
    parameter int TIME_W    = 64,
    parameter int TIMER_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    now,
    input  logic                 arm_val,
    input  logic [FLOW_ID_W-1:0] arm_flow_id,
    input  logic [TIMER_W-1:0]   arm_timer_amnt,
    input  logic                 disarm_val,
    input  logic [FLOW_ID_W-1:0] disarm_flow_id,
    output logic                 to_val,
    output logic [FLOW_ID_W-1:0] to_flow_id,
    output logic [TIMER_W-1:0]   to_timer_amnt,
    input  logic                 to_rdy,
    output logic [FLOW_ID_W:0]   armed_cnt,
    output logic                 dbg_state,
    output logic [FLOW_ID_W-1:0] dbg_ptr
);
    // Event handshake: an event transfers on a rising clk edge where to_val & to_rdy;
    // while to_val is high, to_flow_id and to_timer_amnt hold steady and to_val never drops
    // without a transfer.
    typedef enum logic {SCAN = 1'b0, ISSUE = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [FLOW_NUM-1:0]   r_armed, w_armed_nxt;
    logic [TIME_W-1:0]     r_deadline [FLOW_NUM];
    logic [TIMER_W-1:0]    r_amnt     [FLOW_NUM];
    logic [FLOW_ID_W-1:0]  r_ptr, w_ptr_nxt;
    logic                  r_to_val, w_to_val_nxt;
    logic [FLOW_ID_W-1:0]  r_to_flow_id, w_to_flow_id_nxt;
    logic [TIMER_W-1:0]    r_to_amnt, w_to_amnt_nxt;
    logic [FLOW_ID_W:0]    r_armed_cnt, w_armed_cnt_nxt;

    logic [TIME_W-1:0]     w_diff;
    logic                  w_expired;
    logic                  w_req_on_ptr;
    logic                  w_detect;
    logic                  w_arm_inc;
    logic                  w_disarm_dec;

    // Wrap-safe: the deadline has passed when now - deadline lands in the lower half-range.
    assign w_diff       = now - r_deadline[r_ptr];
    assign w_expired    = r_armed[r_ptr] & ~w_diff[TIME_W-1];
    assign w_req_on_ptr = (arm_val & (arm_flow_id == r_ptr)) |
                          (disarm_val & (disarm_flow_id == r_ptr));
    assign w_detect     = (r_state == SCAN) & w_expired & ~w_req_on_ptr;
    assign w_arm_inc    = arm_val & ~r_armed[arm_flow_id];
    // A disarm that collides with an arm of the same flow loses, so it removes nothing.
    assign w_disarm_dec = disarm_val & r_armed[disarm_flow_id] &
                          ~(arm_val & (arm_flow_id == disarm_flow_id));

    always_comb begin
        w_state_nxt      = r_state;
        w_armed_nxt      = r_armed;
        w_ptr_nxt        = r_ptr;
        w_to_val_nxt     = r_to_val;
        w_to_flow_id_nxt = r_to_flow_id;
        w_to_amnt_nxt    = r_to_amnt;
        w_armed_cnt_nxt  = r_armed_cnt
                         + {{FLOW_ID_W{1'b0}}, w_arm_inc}
                         - {{FLOW_ID_W{1'b0}}, w_disarm_dec}
                         - {{FLOW_ID_W{1'b0}}, w_detect};

        if (disarm_val) w_armed_nxt[disarm_flow_id] = 1'b0;
        if (w_detect)   w_armed_nxt[r_ptr]          = 1'b0;
        if (arm_val)    w_armed_nxt[arm_flow_id]    = 1'b1;

        case (r_state)
            SCAN: begin
                w_ptr_nxt = r_ptr + FLOW_ID_W'(1);
                if (w_detect) begin
                    w_to_val_nxt     = 1'b1;
                    w_to_flow_id_nxt = r_ptr;
                    w_to_amnt_nxt    = r_amnt[r_ptr];
                    w_state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                if (r_to_val && to_rdy) begin
                    w_to_val_nxt = 1'b0;
                    w_state_nxt  = SCAN;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SCAN;
            r_armed      <= '0;
            r_ptr        <= '0;
            r_to_val     <= 1'b0;
            r_to_flow_id <= '0;
            r_to_amnt    <= '0;
            r_armed_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_armed      <= w_armed_nxt;
            r_ptr        <= w_ptr_nxt;
            r_to_val     <= w_to_val_nxt;
            r_to_flow_id <= w_to_flow_id_nxt;
            r_to_amnt    <= w_to_amnt_nxt;
            r_armed_cnt  <= w_armed_cnt_nxt;
        end
    end

    // Tables are only meaningful while the armed bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (arm_val) begin
            r_deadline[arm_flow_id] <= now + TIME_W'(arm_timer_amnt);
            r_amnt[arm_flow_id]     <= arm_timer_amnt;
        end
    end

    assign to_val        = r_to_val;
    assign to_flow_id    = r_to_flow_id;
    assign to_timer_amnt = r_to_amnt;
    assign armed_cnt     = r_armed_cnt;
    assign dbg_state     = r_state;
    assign dbg_ptr       = r_ptr;

endmodule

// File: tb/tb_dd_timeout_sched.sv
// Directed bench for dd_timeout_sched: per-cycle comparison against a flow-table model
// plus literal expectations for each scenario.
module tb_dd_timeout_sched;
    localparam int FLOW_NUM  = 16;
    localparam int FLOW_ID_W = 4;
    localparam int TIME_W    = 64;
    localparam int TIMER_W   = 32;
    localparam logic [63:0] HALF = 64'h8000_0000_0000_0000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [TIME_W-1:0]    now = '0;
    logic                 arm_val = 1'b0;
    logic [FLOW_ID_W-1:0] arm_flow_id = '0;
    logic [TIMER_W-1:0]   arm_timer_amnt = '0;
    logic                 disarm_val = 1'b0;
    logic [FLOW_ID_W-1:0] disarm_flow_id = '0;
    logic                 to_val;
    logic [FLOW_ID_W-1:0] to_flow_id;
    logic [TIMER_W-1:0]   to_timer_amnt;
    logic                 to_rdy = 1'b0;
    logic [FLOW_ID_W:0]   armed_cnt;
    logic                 dbg_state;
    logic [FLOW_ID_W-1:0] dbg_ptr;

    dd_timeout_sched #(
        .FLOW_NUM(FLOW_NUM), .FLOW_ID_W(FLOW_ID_W), .TIME_W(TIME_W), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .now(now),
        .arm_val(arm_val), .arm_flow_id(arm_flow_id), .arm_timer_amnt(arm_timer_amnt),
        .disarm_val(disarm_val), .disarm_flow_id(disarm_flow_id),
        .to_val(to_val), .to_flow_id(to_flow_id), .to_timer_amnt(to_timer_amnt),
        .to_rdy(to_rdy), .armed_cnt(armed_cnt), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    bit                   m_arm [FLOW_NUM];
    logic [TIME_W-1:0]    m_dl  [FLOW_NUM];
    logic [TIMER_W-1:0]   m_am  [FLOW_NUM];
    logic [FLOW_ID_W-1:0] m_ptr = '0;
    bit                   m_pend = 1'b0;
    logic [FLOW_ID_W-1:0] m_fid = '0;
    logic [TIMER_W-1:0]   m_amt = '0;
    logic [FLOW_ID_W-1:0] exp_q[$];
    bit                   m_det;
    logic [FLOW_ID_W-1:0] m_p;

    function automatic logic [FLOW_ID_W:0] model_cnt();
        logic [FLOW_ID_W:0] c = '0;
        for (int i = 0; i < FLOW_NUM; i++) if (m_arm[i]) c = c + 1'b1;
        return c;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < FLOW_NUM; i++) m_arm[i] = 1'b0;
            m_ptr = '0; m_pend = 1'b0; m_fid = '0; m_amt = '0;
        end else begin
            m_det = 1'b0;
            m_p   = m_ptr;
            if (m_pend) begin
                if (to_rdy) begin
                    m_pend = 1'b0;
                    exp_q.push_back(m_fid);
                end
            end else begin
                if (m_arm[m_p] && ((now - m_dl[m_p]) < HALF) &&
                    !(arm_val && arm_flow_id == m_p) && !(disarm_val && disarm_flow_id == m_p))
                    m_det = 1'b1;
                m_ptr = m_ptr + 1'b1;
            end
            if (disarm_val) m_arm[disarm_flow_id] = 1'b0;
            if (m_det) begin
                m_arm[m_p] = 1'b0;
                m_pend = 1'b1;
                m_fid  = m_p;
                m_amt  = m_am[m_p];
            end
            if (arm_val) begin
                m_arm[arm_flow_id] = 1'b1;
                m_dl[arm_flow_id]  = now + 64'(arm_timer_amnt);
                m_am[arm_flow_id]  = arm_timer_amnt;
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    logic [FLOW_ID_W-1:0] got_fid_q[$];
    logic [TIMER_W-1:0]   got_amt_q[$];
    logic [TIME_W-1:0]    got_now_q[$];

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("to_val", 64'(to_val), 64'(m_pend));
            if (m_pend) begin
                check("to_flow_id", 64'(to_flow_id), 64'(m_fid));
                check("to_timer_amnt", 64'(to_timer_amnt), 64'(m_amt));
            end
            check("armed_cnt", 64'(armed_cnt), 64'(model_cnt()));
            check("ptr", 64'(dbg_ptr), 64'(m_ptr));
            check("state", 64'(dbg_state), 64'(m_pend));
            if (rst_n && to_val && to_rdy) begin
                got_fid_q.push_back(to_flow_id);
                got_amt_q.push_back(to_timer_amnt);
                got_now_q.push_back(now);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        now        = now + 64'd1;
        arm_val    = 1'b0;
        disarm_val = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic arm(input logic [FLOW_ID_W-1:0] f, input logic [TIMER_W-1:0] a);
        arm_val = 1'b1; arm_flow_id = f; arm_timer_amnt = a;
        cycle();
    endtask

    task automatic disarm(input logic [FLOW_ID_W-1:0] f);
        disarm_val = 1'b1; disarm_flow_id = f;
        cycle();
    endtask

    // Steps until the next edge will scan flow p.
    task automatic wait_ptr(input logic [FLOW_ID_W-1:0] p, input string name);
        int g = 0;
        while (m_ptr != p && g < 64) begin
            cycle();
            g++;
        end
        check(name, 64'(m_ptr), 64'(p));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int b;
        int g;
        logic [TIME_W-1:0] n0;

        #12;
        check("rst_to_val", 64'(to_val), 64'd0);
        check("rst_to_flow_id", 64'(to_flow_id), 64'd0);
        check("rst_to_amnt", 64'(to_timer_amnt), 64'd0);
        check("rst_armed_cnt", 64'(armed_cnt), 64'd0);
        check("rst_ptr", 64'(dbg_ptr), 64'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: single timer expires once, not before its deadline
        to_rdy = 1'b1;
        now = 64'd100;
        b = got_fid_q.size();
        arm(4'd3, 32'd10);
        check("t1_cnt_armed", 64'(armed_cnt), 64'd1);
        run(40);
        check("t1_ev_count", 64'(got_fid_q.size()), 64'(b + 1));
        check("t1_ev_fid", 64'(got_fid_q[b]), 64'd3);
        check("t1_ev_amnt", 64'(got_amt_q[b]), 64'd10);
        check("t1_ev_not_early", 64'(got_now_q[b] >= 64'd110), 64'd1);
        check("t1_cnt_after", 64'(armed_cnt), 64'd0);

        // 2: re-arm pushes the deadline out, count stays 1
        b  = got_fid_q.size();
        n0 = now;
        arm(4'd5, 32'd50);
        run(19);
        arm(4'd5, 32'd50);
        check("t2_cnt_rearm", 64'(armed_cnt), 64'd1);
        run(40);
        check("t2_no_early_ev", 64'(got_fid_q.size()), 64'(b));
        check("t2_cnt_hold", 64'(armed_cnt), 64'd1);
        run(30);
        check("t2_ev_count", 64'(got_fid_q.size()), 64'(b + 1));
        check("t2_ev_fid", 64'(got_fid_q[b]), 64'd5);
        check("t2_ev_not_early", 64'(got_now_q[b] >= n0 + 64'd70), 64'd1);

        // 3: back-pressure holds the first event and the scan pointer
        to_rdy = 1'b0;
        b = got_fid_q.size();
        wait_ptr(4'd10, "t3_wait_ptr");
        arm(4'd2, 32'd0);
        arm(4'd9, 32'd1);
        run(10);
        check("t3_hold_val", 64'(to_val), 64'd1);
        check("t3_hold_fid", 64'(to_flow_id), 64'd2);
        check("t3_hold_amnt", 64'(to_timer_amnt), 64'd0);
        check("t3_hold_ptr", 64'(dbg_ptr), 64'd3);
        run(20);
        check("t3_still_val", 64'(to_val), 64'd1);
        check("t3_still_fid", 64'(to_flow_id), 64'd2);
        check("t3_still_ptr", 64'(dbg_ptr), 64'd3);
        to_rdy = 1'b1;
        run(25);
        check("t3_ev_count", 64'(got_fid_q.size()), 64'(b + 2));
        check("t3_ev0_fid", 64'(got_fid_q[b]), 64'd2);
        check("t3_ev1_fid", 64'(got_fid_q[b+1]), 64'd9);
        check("t3_ev1_amnt", 64'(got_amt_q[b+1]), 64'd1);

        // 4: deadline wraps past 2^64
        b = got_fid_q.size();
        now = 64'hFFFF_FFFF_FFFF_FFFB;
        arm(4'd6, 32'd10);
        run(6);
        check("t4_no_early_ev", 64'(got_fid_q.size()), 64'(b));
        run(30);
        check("t4_ev_count", 64'(got_fid_q.size()), 64'(b + 1));
        check("t4_ev_fid", 64'(got_fid_q[b]), 64'd6);
        check("t4_ev_after_wrap", 64'(got_now_q[b] >= 64'd5 && got_now_q[b] < 64'd100), 64'd1);

        // 5: disarm / re-arm in the detection cycle suppress the event
        b = got_fid_q.size();
        wait_ptr(4'd0, "t5_wait_ptr0");
        arm(4'd7, 32'd0);
        wait_ptr(4'd7, "t5_wait_ptr7");
        disarm(4'd7);
        run(20);
        check("t5_disarm_no_ev", 64'(got_fid_q.size()), 64'(b));
        check("t5_disarm_cnt", 64'(armed_cnt), 64'd0);
        wait_ptr(4'd0, "t5_wait_ptr0b");
        arm(4'd7, 32'd0);
        wait_ptr(4'd7, "t5_wait_ptr7b");
        arm(4'd7, 32'd40);
        run(30);
        check("t5_rearm_no_ev", 64'(got_fid_q.size()), 64'(b));
        check("t5_rearm_cnt", 64'(armed_cnt), 64'd1);
        run(40);
        check("t5_rearm_ev_count", 64'(got_fid_q.size()), 64'(b + 1));
        check("t5_rearm_ev_amnt", 64'(got_amt_q[b]), 64'd40);

        // 6: reset during ISSUE drops the pending event
        to_rdy = 1'b0;
        arm(4'd11, 32'd1000);
        arm(4'd4, 32'd0);
        g = 0;
        while (!to_val && g < 40) begin
            cycle();
            g++;
        end
        check("t6_issue_val", 64'(to_val), 64'd1);
        check("t6_issue_fid", 64'(to_flow_id), 64'd4);
        b = got_fid_q.size();
        rst_n = 1'b0;
        #1;
        check("t6_rst_val", 64'(to_val), 64'd0);
        check("t6_rst_cnt", 64'(armed_cnt), 64'd0);
        run(2);
        rst_n  = 1'b1;
        to_rdy = 1'b1;
        run(40);
        check("t6_no_replay", 64'(got_fid_q.size()), 64'(b));
        check("t6_cnt_after", 64'(armed_cnt), 64'd0);

        check("ev_total", 64'(got_fid_q.size()), 64'(exp_q.size()));
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
